iddr_word_aligner: RTL
======================

# iddr_word_aligner

Sequencing and word-alignment controller for one IDDR input lane. It holds the IDDR in reset after system reset and gates its clock enable. It assembles the two bits per cycle from Q1/Q2 into WORD_W-bit words, then bit-slips the word boundary until a training pattern is seen MATCH_COUNT times in a row. It sits between the IDDR primitive and the lane's downstream word consumer.

## Interface
- WORD_W, 8: word width; even, 4..16.
- TRAIN_PATTERN, 8'hB4: WORD_W-bit training word, MSB is earliest in time.
- MATCH_COUNT, 4: consecutive matches required to lock; 1..15.
- HOLD_CYCLES, 8: cycles IDDR_R is held high after R deasserts; ≥1.
- SETTLE_WORDS, 2: word strobes ignored after each slip and after leaving HOLD; ≥1.
- C  input  1  clock, rising edge used.
- R  input  1  reset, asynchronous, active-high.
- Q1  input  1  IDDR Q1, earlier bit of the pair.
- Q2  input  1  IDDR Q2, later bit of the pair.
- RETRAIN  input  1  single-cycle request to restart alignment.
- IDDR_CE  output  1  clock enable to the IDDR.
- IDDR_R  output  1  reset to the IDDR.
- DATA  output  WORD_W  aligned word.
- DATA_VALID  output  1  one-cycle strobe; DATA is valid when high.
- LOCKED  output  1  level; alignment achieved.
- TRAIN_FAIL  output  1  sticky; a full offset wrap completed without lock.
- SLIP_CNT  output  4  slips since last (re)train, saturates at 15.

## Operation
- **History:** 2*WORD_W-bit shift register. Each cycle with IDDR_CE=1 it shifts left by 2, inserting {Q1,Q2} at bits [1:0].
- **Phase counter:** counts 0..WORD_W/2-1 while IDDR_CE=1. The word strobe is the edge where the phase equals WORD_W/2-1.
- **Word extraction:** word = history[offset+WORD_W-1 : offset], with offset in 0..WORD_W-1.
- **Slip:** offset = (offset+1) mod WORD_W. SLIP_CNT increments, saturating at 15.
- **HOLD:** IDDR_R=1, IDDR_CE=0 for HOLD_CYCLES cycles, then go to FILL.
- **FILL:** IDDR_R=0, IDDR_CE=1. After SETTLE_WORDS strobes, go to SEARCH.
- **SEARCH:** on each strobe:
  - word==TRAIN_PATTERN → VERIFY with match count 1; if MATCH_COUNT==1, go directly to LOCKED.
  - otherwise → SLIP.
- **SLIP:** perform one slip on entry, then wait SETTLE_WORDS strobes, then go to SEARCH.
  - When a slip wraps offset from WORD_W-1 to 0 with no lock since the last (re)train, set TRAIN_FAIL. Searching continues.
- **VERIFY:** on each strobe:
  - match → count+1; when count reaches MATCH_COUNT, go to LOCKED.
  - mismatch → SLIP.
- **LOCKED:** LOCKED=1. Every strobe loads DATA and pulses DATA_VALID. Data mismatches are not checked.
- **RETRAIN:** honoured in any state except HOLD, where it is ignored. Effects:
  - state → SEARCH; LOCKED=0.
  - TRAIN_FAIL, SLIP_CNT and match count cleared.
  - offset is kept; phase counter and history are not disturbed.
- DATA_VALID pulses only in LOCKED. DATA holds its last value otherwise.

## Timing
- **Reset values:** IDDR_R=1, IDDR_CE=0, DATA=0, DATA_VALID=0, LOCKED=0, TRAIN_FAIL=0, SLIP_CNT=0. Internally offset=0, phase=0, history=0, state=HOLD.
- **R mid-operation:** all state returns to the reset values immediately, asynchronously.
- **HOLD exit:** IDDR_R falls and IDDR_CE rises on the same edge, HOLD_CYCLES rising edges after R deasserts.
- **Word latency:** the strobe decision uses the history including that edge's shift. DATA/DATA_VALID are registered on the strobe edge. An input bit pair reaches DATA 1 to WORD_W/2 cycles after capture.
- **Lock timing:** LOCKED rises on the strobe edge of the MATCH_COUNT-th match. The first DATA_VALID is on the next strobe.
- **Slip timing:** the slip takes effect on the edge after the mismatching strobe. The first compared word after a slip is the (SETTLE_WORDS+1)-th strobe.
- **RETRAIN coincident with a strobe:** RETRAIN wins. That strobe is not compared and produces no DATA_VALID.
- **SLIP_CNT:** holds at 15 and never wraps.

## Structure
- Shared package `iddr_ctl_pkg`: FSM state enum (HOLD, FILL, SEARCH, SLIP, VERIFY, LOCKED) and the width constant for SLIP_CNT (4).
- One sub-module, `iddr_gearbox`: history register, phase counter, offset mux and strobe generation. The FSM stays in the top.
- Integration: the top instantiates no IDDR. The integrator wires IDDR_CE/IDDR_R/Q1/Q2 to one IDDR on the same C.

## Test plan
- **Reset sequencing:** R pulse, HOLD_CYCLES=8 → IDDR_R=1 and IDDR_CE=0 for exactly 8 edges after R deasserts, then IDDR_R=0, IDDR_CE=1; all outputs at reset values during hold.
- **Aligned training:** WORD_W=8, stream 0xB4 repeated with boundary offset 0 → LOCKED after 4 compared strobes, SLIP_CNT=0, then DATA=0xB4 with DATA_VALID every 4th cycle.
- **Misaligned training:** stream delayed by 3 bits → exactly 3 slips, SLIP_CNT=3, LOCKED=1, DATA=0xB4.
- **No pattern:** constant 0x00 for 3*8 slips → TRAIN_FAIL=1 after the 8th slip; SLIP_CNT saturates at 15; LOCKED=0, DATA_VALID never pulses.
- **Mismatch in VERIFY:** 0xB4, 0xB4, 0x3C, then aligned 0xB4 → slip on the third word; lock is re-acquired only after a fresh 4 matches.
- **RETRAIN and mid-stream reset:** RETRAIN while LOCKED → LOCKED falls next edge, TRAIN_FAIL and SLIP_CNT are cleared, offset kept, re-locks without slipping. R asserted mid-VERIFY → all outputs return to reset values asynchronously and the HOLD sequence restarts.

Source files
------------

// File: rtl/iddr_ctl_pkg.sv
// Shared types and constants for the IDDR lane alignment controller.
package iddr_ctl_pkg;

    localparam int unsigned SlipCntW = 4;

    typedef enum logic [2:0] {
        StHold,
        StFill,
        StSearch,
        StSlip,
        StVerify,
        StLocked
    } state_e;

endpackage

// File: rtl/iddr_gearbox.sv
// 2:WORD_W gearbox: history shift register, word phase counter and bit-slip offset mux.
module iddr_gearbox
    import iddr_ctl_pkg::*;
#(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              q1,
    input  logic              q2,
    input  logic              slip,
    output logic [WORD_W-1:0] word,
    output logic              strobe,
    output logic              wrap
);

    localparam int unsigned HistW  = 2 * WORD_W;
    localparam int unsigned PhaseW = $clog2(WORD_W / 2);
    localparam int unsigned OffW   = $clog2(WORD_W);
    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(WORD_W / 2 - 1);
    localparam logic [OffW-1:0]   OffLast   = OffW'(WORD_W - 1);

    logic [HistW-1:0]  hist_q;
    logic [HistW-1:0]  hist_shift;
    logic [PhaseW-1:0] phase_q;
    logic [OffW-1:0]   offset_q;

    // Word and strobe see this edge's incoming pair, so compare on the shifted value.
    assign hist_shift = {hist_q[HistW-3:0], q1, q2};
    assign word       = hist_shift[offset_q +: WORD_W];
    assign strobe     = ce && (phase_q == PhaseLast);
    assign wrap       = slip && (offset_q == OffLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q   <= '0;
            phase_q  <= '0;
            offset_q <= '0;
        end else begin
            if (ce) begin
                hist_q  <= hist_shift;
                phase_q <= strobe ? '0 : phase_q + 1'b1;
            end
            if (slip) begin
                offset_q <= wrap ? '0 : offset_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/iddr_word_aligner.sv
// IDDR lane sequencer: holds the IDDR in reset, then bit-slips the word boundary
// until the training pattern is seen MATCH_COUNT times in a row.
module iddr_word_aligner
    import iddr_ctl_pkg::*;
#(
    parameter int unsigned       WORD_W        = 8,
    parameter logic [WORD_W-1:0] TRAIN_PATTERN = 8'hB4,
    parameter int unsigned       MATCH_COUNT   = 4,
    parameter int unsigned       HOLD_CYCLES   = 8,
    parameter int unsigned       SETTLE_WORDS  = 2
) (
    input  logic                C,
    input  logic                R,
    input  logic                Q1,
    input  logic                Q2,
    input  logic                RETRAIN,
    output logic                IDDR_CE,
    output logic                IDDR_R,
    output logic [WORD_W-1:0]   DATA,
    output logic                DATA_VALID,
    output logic                LOCKED,
    output logic                TRAIN_FAIL,
    output logic [SlipCntW-1:0] SLIP_CNT
);

    localparam int unsigned HoldW   = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned SettleW = $clog2(SETTLE_WORDS + 1);
    localparam int unsigned MatchW  = $clog2(MATCH_COUNT + 1);
    localparam logic [HoldW-1:0]   HoldLast   = HoldW'(HOLD_CYCLES - 1);
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_WORDS - 1);
    localparam logic [MatchW-1:0]  MatchLast  = MatchW'(MATCH_COUNT - 1);

    state_e              state_q;
    logic [HoldW-1:0]    hold_cnt_q;
    logic [SettleW-1:0]  settle_cnt_q;
    logic [MatchW-1:0]   match_cnt_q;
    logic                slip_q;
    logic [WORD_W-1:0]   word;
    logic                strobe;
    logic                slip_wrap;
    logic                retrain_go;
    logic                slip_fire;

    assign retrain_go = RETRAIN && (state_q != StHold);
    // A retrain cancels a pending slip so the offset is left untouched.
    assign slip_fire  = slip_q && !retrain_go;

    iddr_gearbox #(
        .WORD_W(WORD_W)
    ) u_gearbox (
        .clk    (C),
        .rst    (R),
        .ce     (IDDR_CE),
        .q1     (Q1),
        .q2     (Q2),
        .slip   (slip_fire),
        .word   (word),
        .strobe (strobe),
        .wrap   (slip_wrap)
    );

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q      <= StHold;
            hold_cnt_q   <= '0;
            settle_cnt_q <= '0;
            match_cnt_q  <= '0;
            slip_q       <= 1'b0;
            IDDR_R       <= 1'b1;
            IDDR_CE      <= 1'b0;
            DATA         <= '0;
            DATA_VALID   <= 1'b0;
            LOCKED       <= 1'b0;
            TRAIN_FAIL   <= 1'b0;
            SLIP_CNT     <= '0;
        end else begin
            DATA_VALID <= 1'b0;
            slip_q     <= 1'b0;
            if (slip_fire) begin
                if (SLIP_CNT != '1) SLIP_CNT <= SLIP_CNT + 1'b1;
                if (slip_wrap) TRAIN_FAIL <= 1'b1;
            end
            if (retrain_go) begin
                state_q      <= StSearch;
                LOCKED       <= 1'b0;
                TRAIN_FAIL   <= 1'b0;
                SLIP_CNT     <= '0;
                match_cnt_q  <= '0;
                settle_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    StHold: begin
                        if (hold_cnt_q == HoldLast) begin
                            state_q    <= StFill;
                            hold_cnt_q <= '0;
                            IDDR_R     <= 1'b0;
                            IDDR_CE    <= 1'b1;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                    StFill, StSlip: begin
                        if (strobe) begin
                            if (settle_cnt_q == SettleLast) begin
                                state_q      <= StSearch;
                                settle_cnt_q <= '0;
                            end else begin
                                settle_cnt_q <= settle_cnt_q + 1'b1;
                            end
                        end
                    end
                    StSearch, StVerify: begin
                        if (strobe) begin
                            if (word != TRAIN_PATTERN) begin
                                state_q      <= StSlip;
                                slip_q       <= 1'b1;
                                settle_cnt_q <= '0;
                                match_cnt_q  <= '0;
                            end else if ((state_q == StSearch && MATCH_COUNT == 1) ||
                                         (state_q == StVerify && match_cnt_q == MatchLast)) begin
                                state_q <= StLocked;
                                LOCKED  <= 1'b1;
                            end else if (state_q == StSearch) begin
                                state_q     <= StVerify;
                                match_cnt_q <= MatchW'(1);
                            end else begin
                                match_cnt_q <= match_cnt_q + 1'b1;
                            end
                        end
                    end
                    StLocked: begin
                        if (strobe) begin
                            DATA       <= word;
                            DATA_VALID <= 1'b1;
                        end
                    end
                    default: state_q <= StHold;
                endcase
            end
        end
    end

endmodule
